// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width, flit field positions and the one-hot
// output-port labels produced by route computation.
package noc_pkg;

  localparam int unsigned DATASIZE = 40;

  // Flit field positions
  localparam int unsigned SRC_HI  = 39;
  localparam int unsigned SRC_LO  = 36;
  localparam int unsigned DST_HI  = 35;
  localparam int unsigned DST_LO  = 32;
  localparam int unsigned TS_HI   = 31;
  localparam int unsigned TS_LO   = 24;
  localparam int unsigned DATA_HI = 23;
  localparam int unsigned DATA_LO = 2;
  localparam int unsigned TYPE_HI = 1;
  localparam int unsigned TYPE_LO = 0;

  // One-hot output-port labels presented to the switch allocator
  localparam logic [3:0] LBL_W     = 4'b1000;
  localparam logic [3:0] LBL_N     = 4'b0100;
  localparam logic [3:0] LBL_E     = 4'b0010;
  localparam logic [3:0] LBL_S     = 4'b0001;
  localparam logic [3:0] LBL_LOCAL = 4'b0000;
  localparam logic [3:0] LBL_NONE  = 4'b1111;

  typedef struct packed {
    logic [3:0]  src;
    logic [3:0]  dst;
    logic [7:0]  ts;
    logic [21:0] data;
    logic [1:0]  kind;
  } flit_t;

  // Returns the flit with its timestamp (hop count) advanced by one, mod 256
  function automatic logic [DATASIZE-1:0] bump_timestamp(input logic [DATASIZE-1:0] f);
    flit_t t;
    t    = flit_t'(f);
    t.ts = t.ts + 8'd1;
    return DATASIZE'(t);
  endfunction

endpackage

// File: rtl/xy_route_calc.sv
// Dimension-order XY route computation for a head flit.
// Purely combinational; shared by every router input port.
module xy_route_calc #(
  parameter int unsigned LOC_X = 1,
  parameter int unsigned LOC_Y = 1
) (
  input  logic [3:0] dst,
  input  logic       empty,
  output logic [3:0] label
);
  import noc_pkg::*;

  localparam logic [1:0] LX = LOC_X[1:0];
  localparam logic [1:0] LY = LOC_Y[1:0];

  logic [1:0] dst_x;
  logic [1:0] dst_y;

  assign dst_x = dst[3:2];
  assign dst_y = dst[1:0];

  // Resolve X first, then Y; no head flit means no request
  always_comb begin
    label = LBL_LOCAL;
    if (empty)             label = LBL_NONE;
    else if (dst_x < LX)   label = LBL_W;
    else if (dst_x > LX)   label = LBL_E;
    else if (dst_y < LY)   label = LBL_N;
    else if (dst_y > LY)   label = LBL_S;
    else                   label = LBL_LOCAL;
  end

endmodule

// File: rtl/input_buffer_route.sv
// Router input port: DEPTH-entry FWFT flit FIFO with XY route label on the head.
// Optional: define IBUF_HOP_COUNT_EN to increment the timestamp field on enqueue.
module input_buffer_route #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned DATASIZE = noc_pkg::DATASIZE,
  parameter int unsigned LOC_X    = 1,
  parameter int unsigned LOC_Y    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATASIZE-1:0] data_in,
  input  logic                data_valid,
  output logic                full,
  input  logic                ready,
  output logic [3:0]          label,
  output logic [DATASIZE-1:0] data_out,
  output logic [WIDTH:0]      count
);
  import noc_pkg::*;

  localparam logic [WIDTH:0] DEPTH_CNT = DEPTH[WIDTH:0];

  logic [DATASIZE-1:0] mem [DEPTH];
  logic [WIDTH-1:0]    wr_ptr;
  logic [WIDTH-1:0]    rd_ptr;
  logic [DATASIZE-1:0] wr_data;
  logic                empty;
  logic                push;
  logic                pop;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);
  assign push  = data_valid & ~full;
  assign pop   = ready & ~empty;

  // Flit as it will be stored (hop count optionally advanced)
  always_comb begin
    wr_data = data_in;
`ifdef IBUF_HOP_COUNT_EN
    wr_data = bump_timestamp(data_in);
`endif
  end

  // Storage array; deliberately not reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign data_out = mem[rd_ptr];

  xy_route_calc #(
    .LOC_X (LOC_X),
    .LOC_Y (LOC_Y)
  ) u_route (
    .dst   (data_out[DST_HI:DST_LO]),
    .empty (empty),
    .label (label)
  );

endmodule

// File: tb/tb_input_buffer_route.sv
module tb_input_buffer_route;

  localparam int DS = 40;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DS-1:0] data_in;
  logic          data_valid;
  logic          full;
  logic          ready;
  logic [3:0]    label;
  logic [DS-1:0] data_out;
  logic [3:0]    count;

  int checks = 0;
  int failures = 0;

  logic [DS-1:0] model_q[$];  // flits held in the buffer, as they must read out
  logic [DS-1:0] src_q[$];    // upstream sender's pending flits
  logic          full_s = 1'b0;

  input_buffer_route #(
    .DEPTH(8), .WIDTH(3), .DATASIZE(40), .LOC_X(1), .LOC_Y(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .full(full), .ready(ready), .label(label), .data_out(data_out), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DS-1:0] mk(input int s, input int d, input int ts, input int dat);
    logic [DS-1:0] f;
    f = {s[3:0], d[3:0], ts[7:0], dat[21:0], 2'b01};
    return f;
  endfunction

  function automatic logic [DS-1:0] stored(input logic [DS-1:0] f);
    logic [DS-1:0] r;
    r = f;
`ifdef IBUF_HOP_COUNT_EN
    r[31:24] = f[31:24] + 8'd1;
`endif
    return r;
  endfunction

  // XY routing decision from destination coordinates, router at (1,1)
  function automatic logic [3:0] route(input logic [DS-1:0] f);
    int x, y;
    x = int'(f[35:34]);
    y = int'(f[33:32]);
    if (x < 1) return 4'b1000;
    if (x > 1) return 4'b0010;
    if (y < 1) return 4'b0100;
    if (y > 1) return 4'b0001;
    return 4'b0000;
  endfunction

  // Behavioural model: a bounded queue of 8 flits
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_q.delete();
    else begin
      bit do_push, do_pop;
      do_push = data_valid && (model_q.size() < 8);
      do_pop  = ready && (model_q.size() > 0);
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(stored(data_in));
    end
  end

  // Upstream sender: holds its flit until it is accepted
  always @(posedge clk) begin
    if (rst_n && data_valid && !full_s && src_q.size() > 0) void'(src_q.pop_front());
  end
  always @(negedge clk) begin
    full_s = full;
    data_valid = (src_q.size() > 0);
    data_in = (src_q.size() > 0) ? src_q[0] : '0;
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      check("count", 64'(count), 64'(model_q.size()));
      check("full", 64'(full), 64'(model_q.size() == 8));
      check("label", 64'(label), model_q.size() == 0 ? 64'hF : 64'(route(model_q[0])));
      if (model_q.size() > 0) check("data_out", 64'(data_out), 64'(model_q[0]));
    end
  end

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk); #1;
      if (src_q.size() == 0 && !data_valid) done = 1'b1;
    end
    if (!done) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_empty(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk); #1;
      if (src_q.size() == 0 && model_q.size() == 0) done = 1'b1;
    end
    if (!done) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  logic [3:0] dsts[5]  = '{4'b0101, 4'b0001, 4'b1001, 4'b0100, 4'b0110};
  logic [3:0] labs[5]  = '{4'b0000, 4'b1000, 4'b0010, 4'b0100, 4'b0001};

  initial begin
    rst_n = 1'b0; ready = 1'b0; data_valid = 1'b0; data_in = '0;
    #12 rst_n = 1'b1;

    // Reset state and idle ready
    @(negedge clk); #1;
    check("rst_full", 64'(full), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_label", 64'(label), 64'hF);
    ready = 1'b1;
    repeat (2) @(negedge clk);
    #1 ready = 1'b0;
    check("ready_empty_count", 64'(count), 64'd0);

    // Route labels for each destination
    for (int i = 0; i < 5; i++) begin
      logic [DS-1:0] f;
      f = mk(3, int'(dsts[i]), 16 * i + 1, 22'h2A5A5 + i);
      src_q.push_back(f);
      wait_drain("single_push");
      check("route_label", 64'(label), 64'(labs[i]));
      check("route_data", 64'(data_out), 64'(stored(f)));
      ready = 1'b1;
      @(negedge clk); #1 ready = 1'b0;
      check("route_popped", 64'(count), 64'd0);
    end

    // Fill to full with a held 9th/10th flit, then drain across wrap
    for (int i = 0; i < 10; i++) src_q.push_back(mk(i, 4'b0110 + i[1:0], i, 22'h1000 + i));
    repeat (10) @(negedge clk);
    #1;
    check("fill_full", 64'(full), 64'd1);
    check("fill_count", 64'(count), 64'd8);
    check("fill_held", 64'(src_q.size()), 64'd2);
    ready = 1'b1;
    wait_empty("drain");
    ready = 1'b0;

    // Steady push+pop at occupancy 3
    for (int i = 0; i < 3; i++) src_q.push_back(mk(7, 4'b1010, 100 + i, 22'h3000 + i));
    wait_drain("prefill3");
    check("prefill3_count", 64'(count), 64'd3);
    for (int i = 0; i < 20; i++) src_q.push_back(mk(9, i[3:0], 200 + i, 22'h4000 + i));
    @(negedge clk); #1 ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      check("steady_count", 64'(count), 64'd3);
    end
    ready = 1'b0;
    ready = 1'b1;
    wait_empty("steady_drain");
    ready = 1'b0;

    // Mid-operation asynchronous reset
    for (int i = 0; i < 5; i++) src_q.push_back(mk(2, 4'b0000, 50 + i, 22'h5000 + i));
    wait_drain("prefill5");
    check("prefill5_count", 64'(count), 64'd5);
    #2 rst_n = 1'b0;
    src_q.delete();
    #1;
    check("arst_label", 64'(label), 64'hF);
    check("arst_full", 64'(full), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    src_q.push_back(mk(1, 4'b0111, 9, 22'h6001));
    src_q.push_back(mk(1, 4'b1101, 10, 22'h6002));
    wait_drain("post_reset");
    check("post_reset_count", 64'(count), 64'd2);
    check("post_reset_label", 64'(label), 64'(4'b0001));
    ready = 1'b1;
    wait_empty("post_reset_drain");
    ready = 1'b0;

`ifdef IBUF_HOP_COUNT_EN
    src_q.push_back(mk(4, 4'b0101, 255, 22'h7777));
    wait_drain("hop");
    check("hop_wrap", 64'(data_out[31:24]), 64'h00);
    ready = 1'b1;
    wait_empty("hop_drain");
    ready = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
